// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU operation encodings and FSM state type for the EX-stage execute unit.
// The aluCnt encodings must stay in sync with the ALU control decoder.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result bus between the ID/EX pipeline and the execute unit.
// The overflow flag exists only when ALU_OVERFLOW_EN is defined.
interface alu_exec_unit_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       aluCnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef ALU_OVERFLOW_EN
  logic             overflow;

  modport master (output in_valid, aluCnt, a, b,
                  input  in_ready, stall, out_valid, result, zero, overflow);
  modport slave  (input  in_valid, aluCnt, a, b,
                  output in_ready, stall, out_valid, result, zero, overflow);
`else
  modport master (output in_valid, aluCnt, a, b,
                  input  in_ready, stall, out_valid, result, zero);
  modport slave  (input  in_valid, aluCnt, a, b,
                  output in_ready, stall, out_valid, result, zero);
`endif

endinterface

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle while run_i is high.
// done_o flags the WIDTH-th iteration; prod_o is the accumulator value that iteration produces.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q,  mplr_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] accSum;

  assign accSum = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      mcand_d = a_i;
      mplr_d  = b_i;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (run_i) begin
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      acc_d   = accSum;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done_o = run_i && (cnt_q == LAST_ITER);
  assign prod_o = accSum;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: single-cycle logic/arith ops plus a WIDTH-cycle iterative MUL.
// Build option: define ALU_OVERFLOW_EN to add the registered signed-overflow flag.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             outValid_q, outValid_d;
  logic             inReady, mulStart, mulRun, mulDone;
  logic [WIDTH-1:0] mulProd, sum, diff, opRes;
  logic             subOvf;
`ifdef ALU_OVERFLOW_EN
  logic             addOvf, opOvf, ovf_q, ovf_d;
`endif

  assign sum    = bus.a + bus.b;
  assign diff   = bus.a - bus.b;
  assign subOvf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);

  // SLT takes the sign of a-b corrected by overflow so it stays right across the wrap.
  always_comb begin
    opRes = '0;
    case (bus.aluCnt)
      ALU_AND: opRes = bus.a & bus.b;
      ALU_OR:  opRes = bus.a | bus.b;
      ALU_ADD: opRes = sum;
      ALU_SUB: opRes = diff;
      ALU_SLT: opRes = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ subOvf};
      ALU_NOR: opRes = ~(bus.a | bus.b);
      ALU_XOR: opRes = bus.a ^ bus.b;
      default: opRes = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  assign addOvf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
  assign opOvf  = (bus.aluCnt == ALU_ADD) ? addOvf :
                  (bus.aluCnt == ALU_SUB) ? subOvf : 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    inReady    = 1'b0;
    mulStart   = 1'b0;
    mulRun     = 1'b0;
    outValid_d = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
`ifdef ALU_OVERFLOW_EN
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          if (bus.aluCnt == ALU_MUL) begin
            mulStart = 1'b1;
            state_d  = ST_MUL_BUSY;
          end else begin
            outValid_d = 1'b1;
            result_d   = opRes;
            zero_d     = (opRes == '0);
`ifdef ALU_OVERFLOW_EN
            ovf_d      = opOvf;
`endif
          end
        end
      end
      ST_MUL_BUSY: begin
        mulRun = 1'b1;
        if (mulDone) begin
          state_d    = ST_IDLE;
          outValid_d = 1'b1;
          result_d   = mulProd;
          zero_d     = (mulProd == '0);
`ifdef ALU_OVERFLOW_EN
          ovf_d      = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      outValid_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      outValid_q <= outValid_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mulStart),
    .run_i   (mulRun),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (mulDone),
    .prod_o  (mulProd)
  );

  assign bus.in_ready  = inReady;
  assign bus.stall     = bus.in_valid && !inReady;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
`ifdef ALU_OVERFLOW_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed ops, scoreboard of expected results.
// Overflow checks are included when ALU_OVERFLOW_EN is defined.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t sbQ[$];
  exp_t mon;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model built from plain arithmetic, independent of the RTL datapath.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] av, bv, input string tag);
    exp_t        e;
    logic [63:0] p;
    logic [32:0] s;
    e.tag = tag;
    e.ovf = 1'b0;
    e.res = '0;
    case (op)
      ALU_AND: e.res = av & bv;
      ALU_OR:  e.res = av | bv;
      ALU_NOR: e.res = ~(av | bv);
      ALU_XOR: e.res = av ^ bv;
      ALU_ADD: begin
        s = {av[31], av} + {bv[31], bv};
        e.res = s[31:0];
        e.ovf = s[32] ^ s[31];
      end
      ALU_SUB: begin
        s = {av[31], av} - {bv[31], bv};
        e.res = s[31:0];
        e.ovf = s[32] ^ s[31];
      end
      ALU_SLT: e.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      ALU_MUL: begin
        p = {32'd0, av} * {32'd0, bv};
        e.res = p[31:0];
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expValid);
    check(tag, {31'd0, bus.out_valid}, {31'd0, expValid});
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av, bv,
                               input string tag, input bit push);
    int w;
    bus.in_valid = 1'b1;
    bus.aluCnt   = op;
    bus.a        = av;
    bus.b        = bv;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_accepted"}, {31'd0, (w < 100)}, 32'd1);
    if (push) sbQ.push_back(model(op, av, bv, tag));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitOut(input string tag, inout int lat);
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_seen"}, {31'd0, (lat < 200)}, 32'd1);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      compared++;
      assert (sbQ.size() > 0)
      else begin
        mismatched++;
        $error("[TB] FAIL unexpected_out_valid observed=1 expected=0");
      end
      if (sbQ.size() > 0) begin
        mon = sbQ.pop_front();
        check({mon.tag, "_result"}, bus.result, mon.res);
        check({mon.tag, "_zero"}, {31'd0, bus.zero}, {31'd0, mon.z});
`ifdef ALU_OVERFLOW_EN
        check({mon.tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, mon.ovf});
`endif
      end
    end
  end

  initial begin
    int lat;
    int pulses;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.aluCnt   = ALU_AND;
    bus.a        = '0;
    bus.b        = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_valid", 1'b0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd0);
`ifdef ALU_OVERFLOW_EN
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] back-to-back ADD/SUB");
    applyStimulus(ALU_ADD, 32'd7, 32'd5, "add_7_5", 1'b1);
    checkOutput("add_valid", 1'b1);
    applyStimulus(ALU_SUB, 32'd5, 32'd7, "sub_5_7", 1'b1);
    checkOutput("sub_valid", 1'b1);
    check("sub_5_7_value", bus.result, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    checkOutput("pulse_ends", 1'b0);

    $display("[TB] SLT / zero / logic ops");
    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, "slt_neg", 1'b1);
    applyStimulus(ALU_SLT, 32'd1, 32'hFFFF_FFFF, "slt_pos", 1'b1);
    applyStimulus(ALU_SUB, 32'd3, 32'd3, "sub_3_3", 1'b1);
    check("sub_3_3_zero", {31'd0, bus.zero}, 32'd1);
    applyStimulus(ALU_AND, 32'hF0F0_1234, 32'h0FF0_8765, "and_pat", 1'b1);
    applyStimulus(ALU_OR,  32'hF0F0_1234, 32'h0FF0_8765, "or_pat", 1'b1);
    applyStimulus(ALU_NOR, 32'hF0F0_1234, 32'h0FF0_8765, "nor_pat", 1'b1);
    applyStimulus(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_8765, "xor_pat", 1'b1);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset while idle with a held result");
    rst_n = 1'b0;
    #2;
    check("rst2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst2_out_valid", 1'b0);
    check("rst2_result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] MUL 1234*5678 with held in_valid");
    applyStimulus(ALU_MUL, 32'd1234, 32'd5678, "mul_1234_5678", 1'b1);
    lat = 1;
    bus.in_valid = 1'b1;
    bus.aluCnt   = ALU_ADD;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      check("mul_stall", {31'd0, bus.stall}, 32'd1);
      check("mul_busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    #1;
    check("mul_stall_released", {31'd0, bus.stall}, 32'd0);
    waitOut("mul_1234_5678", lat);
    check("mul_latency", lat, 32'd33);
    check("mul_value", bus.result, 32'd7006652);
    check("mul_done_in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("[TB] MUL wrap, then aborted MUL");
    applyStimulus(ALU_MUL, 32'hFFFF_FFFF, 32'd2, "mul_wrap", 1'b1);
    lat = 1;
    waitOut("mul_wrap", lat);
    check("mul_wrap_latency", lat, 32'd33);
    applyStimulus(ALU_MUL, 32'd99, 32'd77, "mul_abort", 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("abort_out_valid", 1'b0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    check("abort_no_pulse", pulses, 32'd0);
    check("abort_idle_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("[TB] overflow boundary");
    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, "add_ovf", 1'b1);
    check("add_ovf_value", bus.result, 32'h8000_0000);
    applyStimulus(ALU_AND, 32'h7FFF_FFFF, 32'd1, "and_no_ovf", 1'b1);
    applyStimulus(ALU_SUB, 32'h8000_0000, 32'd1, "sub_ovf", 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sbQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
